vector_serializer: RTL and testbench

Drain side of the vector arithmetic units (divide/multiply vector arrays): captures each N-element result vector presented with a valid strobe, buffers up to DEPTH vectors, and emits the elements one at a time, index 0 first, on a scalar valid/ready stream. The vector units are fixed-latency pipelines with no stall input, so this block absorbs bursts and flags any vector it cannot store.

---
 rtl/vector_serializer.sv | 122 ++++++++++++
 tb/tb_vector_serializer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vector_serializer.sv
`default_nettype none
// ============================================================================
// Module   : vector_serializer
// Purpose  : Buffers up to DEPTH N-element result vectors and emits their
//            elements one at a time (index 0 first) on a valid/ready stream.
//            Vectors that arrive while the buffer is full are dropped and
//            flagged on the sticky overflow output.
// Options  : VECTOR_SERIALIZER_DROP_COUNT_EN adds an 8-bit saturating
//            drop_count output.
// Revision : 1.0 - initial release
// ============================================================================
module vector_serializer #(
  parameter int BITS  = 16,
  parameter int N     = 3,
  parameter int DEPTH = 4,
  localparam int IW   = (N > 1) ? $clog2(N) : 1,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [BITS-1:0] in_data [N],
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_data,
  output logic [IW-1:0]   out_index,
  output logic            out_last,
`ifdef VECTOR_SERIALIZER_DROP_COUNT_EN
  output logic [7:0]      drop_count,
`endif
  output logic            overflow,
  output logic [LW-1:0]   level
);

  localparam int PW = $clog2(DEPTH);

  logic [BITS-1:0] mem_q [DEPTH][N];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [IW-1:0]   elem_q, elem_d;
  logic [LW-1:0]   level_q, level_d;
  logic            push, pop, hs, drop;

`ifdef VECTOR_SERIALIZER_DROP_COUNT_EN
  logic [7:0] drop_count_q, drop_count_d;
`else
  logic       overflow_q, overflow_d;
`endif

  always_comb begin
    out_valid = (level_q != '0);
    out_index = elem_q;
    out_last  = (elem_q == IW'(N - 1));
    out_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (elem_q == IW'(i)) out_data = mem_q[rptr_q][i];
    end

    hs       = out_valid && out_ready;
    pop      = hs && out_last;
    // A completing head vector frees its slot in time for a same-cycle write
    in_ready = (level_q < LW'(DEPTH)) || pop;
    push     = in_valid && in_ready;
    drop     = in_valid && !in_ready;

    elem_d = elem_q;
    if (hs) elem_d = out_last ? '0 : elem_q + 1'b1;

    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
    level_d = level_q;
    if (push && !pop) level_d = level_q + 1'b1;
    if (pop && !push) level_d = level_q - 1'b1;

`ifdef VECTOR_SERIALIZER_DROP_COUNT_EN
    drop_count_d = drop_count_q;
    if (drop && drop_count_q != 8'hFF) drop_count_d = drop_count_q + 1'b1;
`else
    overflow_d = overflow_q || drop;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      elem_q  <= '0;
      level_q <= '0;
`ifdef VECTOR_SERIALIZER_DROP_COUNT_EN
      drop_count_q <= '0;
`else
      overflow_q   <= 1'b0;
`endif
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      elem_q  <= elem_d;
      level_q <= level_d;
`ifdef VECTOR_SERIALIZER_DROP_COUNT_EN
      drop_count_q <= drop_count_d;
`else
      overflow_q   <= overflow_d;
`endif
    end
  end

  // Storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wptr_q] <= in_data;
  end

  assign level = level_q;
`ifdef VECTOR_SERIALIZER_DROP_COUNT_EN
  assign drop_count = drop_count_q;
  assign overflow   = (drop_count_q != 8'h00);
`else
  assign overflow   = overflow_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vector_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_serializer
// Purpose  : Directed scoreboard bench for vector_serializer (N=3 and N=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vector_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data [3];
  logic        in_ready, out_valid, out_ready, out_last, overflow;
  logic [15:0] out_data;
  logic [1:0]  out_index;
  logic [2:0]  level;
`ifdef VECTOR_SERIALIZER_DROP_COUNT_EN
  logic [7:0]  drop_count;
`endif

  logic        n1_in_valid, n1_in_ready, n1_out_valid, n1_out_ready, n1_out_last, n1_overflow;
  logic [15:0] n1_in_data [1];
  logic [15:0] n1_out_data;
  logic [0:0]  n1_out_index;
  logic [2:0]  n1_level;
`ifdef VECTOR_SERIALIZER_DROP_COUNT_EN
  logic [7:0]  n1_drop_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n1_outs  = 0;

  logic [18:0] sb [$];   // {last, index[1:0], data[15:0]}
  logic [15:0] sb1 [$];

  always #5 clk = ~clk;

  vector_serializer #(.BITS(16), .N(3), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last),
`ifdef VECTOR_SERIALIZER_DROP_COUNT_EN
    .drop_count(drop_count),
`endif
    .overflow(overflow), .level(level)
  );

  vector_serializer #(.BITS(16), .N(1), .DEPTH(4)) dut_n1 (
    .clk(clk), .rst(rst), .in_valid(n1_in_valid), .in_data(n1_in_data), .in_ready(n1_in_ready),
    .out_valid(n1_out_valid), .out_ready(n1_out_ready), .out_data(n1_out_data),
    .out_index(n1_out_index), .out_last(n1_out_last),
`ifdef VECTOR_SERIALIZER_DROP_COUNT_EN
    .drop_count(n1_drop_count),
`endif
    .overflow(n1_overflow), .level(n1_level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare any element transfer happening this cycle, then advance one clock.
  task automatic cycle();
    logic [18:0] e;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_output", {16'h0, out_data}, 32'hFFFF_FFFF);
      else begin
        e = sb.pop_front();
        chk("out_data",  {16'h0, out_data}, {16'h0, e[15:0]});
        chk("out_index", {30'h0, out_index}, {30'h0, e[17:16]});
        chk("out_last",  {31'h0, out_last}, {31'h0, e[18]});
      end
    end
    if (n1_out_valid && n1_out_ready) begin
      n1_outs++;
      if (sb1.size() == 0) chk("n1_unexpected_output", {16'h0, n1_out_data}, 32'hFFFF_FFFF);
      else chk("n1_out_data", {16'h0, n1_out_data}, {16'h0, sb1.pop_front()});
      chk("n1_out_index", {31'h0, n1_out_index}, 32'h0);
      chk("n1_out_last",  {31'h0, n1_out_last}, 32'h1);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a vector for one cycle; expected elements enter the scoreboard if accepted.
  task automatic send(input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                      input bit accept);
    in_valid   = 1'b1;
    in_data[0] = d0;
    in_data[1] = d1;
    in_data[2] = d2;
    if (accept) begin
      sb.push_back({1'b0, 2'd0, d0});
      sb.push_back({1'b0, 2'd1, d1});
      sb.push_back({1'b1, 2'd2, d2});
    end
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    sb.delete();
    sb1.delete();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_data[0] = '0; in_data[1] = '0; in_data[2] = '0;
    n1_in_valid = 1'b0; n1_out_ready = 1'b0; n1_in_data[0] = '0;
    @(negedge clk);
    do_reset();

    // Reset state
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_index", {30'h0, out_index}, 32'h0);
    chk("rst_out_last",  {31'h0, out_last}, 32'h0);
    chk("rst_level",     {29'h0, level}, 32'h0);
    chk("rst_overflow",  {31'h0, overflow}, 32'h0);
    chk("rst_in_ready",  {31'h0, in_ready}, 32'h1);
    chk("rst_n1_out_last", {31'h0, n1_out_last}, 32'h1);

    // Single vector, one element per cycle starting the cycle after the write
    out_ready = 1'b1;
    send(16'h3C00, 16'h4000, 16'h4200, 1'b1);
    chk("single_valid_t1", {31'h0, out_valid}, 32'h1);
    chk("single_level", {29'h0, level}, 32'h1);
    for (int i = 0; i < 3; i++) cycle();
    chk("single_level_after", {29'h0, level}, 32'h0);
    chk("single_sb_empty", sb.size(), 32'h0);

    // Backpressure: output held steady while stalled
    out_ready = 1'b0;
    send(16'hA000, 16'hA001, 16'hA002, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_data",  {16'h0, out_data}, 32'hA000);
      chk("stall_index", {30'h0, out_index}, 32'h0);
      cycle();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    chk("stall_sb_empty", sb.size(), 32'h0);
    chk("stall_level", {29'h0, level}, 32'h0);

    // Fill four, fifth is dropped, drain in order
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++)
      send(16'h1000 + 16'(k * 16), 16'h1001 + 16'(k * 16), 16'h1002 + 16'(k * 16), 1'b1);
    chk("fill_level", {29'h0, level}, 32'h4);
    chk("fill_in_ready", {31'h0, in_ready}, 32'h0);
    chk("fill_overflow_pre", {31'h0, overflow}, 32'h0);
    send(16'h1050, 16'h1051, 16'h1052, 1'b0);
    chk("drop_overflow", {31'h0, overflow}, 32'h1);
    chk("drop_level", {29'h0, level}, 32'h4);
`ifdef VECTOR_SERIALIZER_DROP_COUNT_EN
    chk("drop_count", {24'h0, drop_count}, 32'h1);
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) cycle();
    chk("drain_sb_empty", sb.size(), 32'h0);
    chk("drain_level", {29'h0, level}, 32'h0);
    chk("drain_overflow_sticky", {31'h0, overflow}, 32'h1);

    // Full buffer accepting a vector as the head completes
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++)
      send(16'h2000 + 16'(k * 16), 16'h2001 + 16'(k * 16), 16'h2002 + 16'(k * 16), 1'b1);
    out_ready = 1'b1;
    cycle();
    cycle();
    chk("full_pop_index", {30'h0, out_index}, 32'h2);
    chk("full_pop_in_ready", {31'h0, in_ready}, 32'h1);
    send(16'h2F00, 16'h2F01, 16'h2F02, 1'b1);
    chk("full_pop_level", {29'h0, level}, 32'h4);
    chk("full_pop_overflow", {31'h0, overflow}, 32'h0);
    for (int i = 0; i < 12; i++) cycle();
    chk("full_pop_sb_empty", sb.size(), 32'h0);
    chk("full_pop_level_end", {29'h0, level}, 32'h0);

    // Reset in the middle of a vector
    send(16'h3000, 16'h3001, 16'h3002, 1'b1);
    cycle();
    chk("mid_index", {30'h0, out_index}, 32'h1);
    out_ready = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    sb.delete();
    chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
    chk("mid_rst_level", {29'h0, level}, 32'h0);
    chk("mid_rst_overflow", {31'h0, overflow}, 32'h0);
    chk("mid_rst_in_ready", {31'h0, in_ready}, 32'h1);
    out_ready = 1'b1;
    send(16'h3100, 16'h3101, 16'h3102, 1'b1);
    for (int i = 0; i < 3; i++) cycle();
    chk("mid_sb_empty", sb.size(), 32'h0);

    // N=1: every element is last, one pop per handshake
    n1_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n1_in_valid = 1'b1;
      n1_in_data[0] = 16'h5000 + 16'(k);
      sb1.push_back(16'h5000 + 16'(k));
      cycle();
    end
    n1_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    chk("n1_outputs", n1_outs, 32'h3);
    chk("n1_sb_empty", sb1.size(), 32'h0);
    chk("n1_level", {29'h0, n1_level}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
